// File: rtl/mmio_dmem.sv
`timescale 1ns/1ps
// Data memory plus memory-mapped LEDs, switches, 7-seg register and compare timer.
// Latency: loads are combinational in the same cycle; stores and timer updates land on the next rising edge.
// Backpressure: none; the core is never stalled, and every access completes in one cycle.
module mmio_dmem #(
  parameter int RAM_WORDS = 64,  // power of two, 2..256
  parameter int PRESCALE  = 1    // clock cycles per timer tick, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic [15:0] seg_value,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  // Word offsets inside the 0x400 peripheral block.
  localparam logic [2:0] REG_LEDS   = 3'd0;
  localparam logic [2:0] REG_SW     = 3'd1;
  localparam logic [2:0] REG_TCOUNT = 3'd2;
  localparam logic [2:0] REG_TCMP   = 3'd3;
  localparam logic [2:0] REG_TCTRL  = 3'd4;
  localparam logic [2:0] REG_SEG    = 3'd5;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          periph_hit;
  logic [2:0]    reg_sel;
  logic          addr_unused;

  logic [15:0]   sw_meta;
  logic [15:0]   sw_sync;

  logic [31:0]   tcount;
  logic [31:0]   tcmp;
  logic          en;
  logic          auto_rl;
  logic          flag;
  logic [PW-1:0] presc;
  logic          tick;
  logic          match;

  logic we_leds, we_tcount, we_tcmp, we_tctrl, we_seg;

  // Full 32-bit decode: RAM occupies the bottom 4*RAM_WORDS bytes, peripherals 0x400-0x41F.
  assign ram_hit     = (addr[31:AW+2] == '0);
  assign ram_idx     = addr[AW+1:2];
  assign periph_hit  = (addr[31:5] == 27'h20);
  assign reg_sel     = addr[4:2];
  assign addr_unused = ^addr[1:0];

  assign we_leds   = memwrite && periph_hit && (reg_sel == REG_LEDS);
  assign we_tcount = memwrite && periph_hit && (reg_sel == REG_TCOUNT);
  assign we_tcmp   = memwrite && periph_hit && (reg_sel == REG_TCMP);
  assign we_tctrl  = memwrite && periph_hit && (reg_sel == REG_TCTRL);
  assign we_seg    = memwrite && periph_hit && (reg_sel == REG_SEG);

  // A tick fires on the last prescaler phase; a match is a tick that finds TCOUNT at TCMP.
  assign tick  = en && (presc == PS_LAST);
  assign match = tick && (tcount == tcmp);

  assign timer_irq = flag;

  // Data RAM: store-only port, no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (memwrite && ram_hit && !reset) begin
      ram[ram_idx] <= writedata;
    end
  end

  // LED and 7-segment value registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds      <= '0;
      seg_value <= '0;
    end else begin
      if (we_leds) leds      <= writedata[15:0];
      if (we_seg)  seg_value <= writedata[15:0];
    end
  end

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  // Prescaler, counter, compare and control; later assignments carry the higher priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      tcount  <= '0;
      tcmp    <= '1;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      flag    <= 1'b0;
    end else begin
      if (!en || tick) presc <= '0;
      else             presc <= presc + PW'(1);

      // Software write to TCOUNT beats the tick; a one-shot match holds the count.
      if (we_tcount) begin
        tcount <= writedata;
      end else if (tick) begin
        if (!match)       tcount <= tcount + 32'd1;
        else if (auto_rl) tcount <= '0;
      end

      if (we_tcmp) tcmp <= writedata;

      if (we_tctrl) begin
        en      <= writedata[0];
        auto_rl <= writedata[1];
      end
      // One-shot match disables the timer even if software just enabled it.
      if (match && !auto_rl) en <= 1'b0;

      // Hardware set wins over a coincident write-1-clear.
      if (match)                        flag <= 1'b1;
      else if (we_tctrl && writedata[2]) flag <= 1'b0;
    end
  end

  // Load mux: combinational from address and current state; unmapped reads return 0.
  always_comb begin
    readdata = '0;
    if (ram_hit) begin
      readdata = ram[ram_idx];
    end else if (periph_hit) begin
      case (reg_sel)
        REG_LEDS:   readdata = {16'h0, leds};
        REG_SW:     readdata = {16'h0, sw_sync};
        REG_TCOUNT: readdata = tcount;
        REG_TCMP:   readdata = tcmp;
        REG_TCTRL:  readdata = {29'h0, flag, auto_rl, en};
        REG_SEG:    readdata = {16'h0, seg_value};
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_dmem.sv
`timescale 1ns/1ps
// Bench for mmio_dmem: two instances (PRESCALE 1 and 4) share one bus.
// Latency: outputs are sampled 1ns after the falling edge, inputs change on the falling edge.
// Backpressure: none; one access is driven per clock.
module tb_mmio_dmem;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [15:0] switches;
  logic [31:0] rd   [2];
  logic [15:0] ld   [2];
  logic [15:0] sg   [2];
  logic        irq  [2];

  int errs   = 0;
  int checks = 0;

  mmio_dmem #(.RAM_WORDS(64), .PRESCALE(1)) u_dut0 (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
    .readdata(rd[0]), .switches(switches), .leds(ld[0]), .seg_value(sg[0]), .timer_irq(irq[0]));

  mmio_dmem #(.RAM_WORDS(64), .PRESCALE(4)) u_dut1 (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
    .readdata(rd[1]), .switches(switches), .leds(ld[1]), .seg_value(sg[1]), .timer_irq(irq[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state as the programmer sees it.
  logic [31:0] m_ram [64];
  bit          m_ok  [64];
  logic [15:0] m_leds, m_seg, m_s1, m_s2;
  logic [31:0] m_tcount [2];
  logic [31:0] m_tcmp   [2];
  bit          m_en [2], m_auto [2], m_flag [2];
  int          m_phase [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mexp(input int k, input logic [31:0] a, output bit known);
    logic [31:0] wa;
    wa    = {a[31:2], 2'b00};
    known = 1'b1;
    if (wa < 32'd256) begin
      known = m_ok[wa[7:2]];
      return m_ram[wa[7:2]];
    end
    case (wa)
      32'h400: return {16'h0, m_leds};
      32'h404: return {16'h0, m_s2};
      32'h408: return m_tcount[k];
      32'h40C: return m_tcmp[k];
      32'h410: return {29'h0, m_flag[k], m_auto[k], m_en[k]};
      32'h414: return {16'h0, m_seg};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_leds = '0; m_seg = '0; m_s1 = '0; m_s2 = '0;
    for (int k = 0; k < 2; k++) begin
      m_tcount[k] = '0; m_tcmp[k] = '1;
      m_en[k] = 0; m_auto[k] = 0; m_flag[k] = 0; m_phase[k] = 0;
    end
    for (int i = 0; i < 64; i++) m_ok[i] = 0;
  endtask

  // One rising edge of the architectural rules, using the pre-edge state.
  task automatic model_step(input bit rst, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [15:0] sw);
    logic [31:0] wa, n_count;
    bit tick, hit, n_en, n_flag;
    int p;
    if (rst) begin
      model_reset();
      return;
    end
    wa = {a[31:2], 2'b00};
    m_s2 = m_s1;
    m_s1 = sw;
    if (we && wa < 32'd256) begin
      m_ram[wa[7:2]] = wd;
      m_ok[wa[7:2]]  = 1;
    end
    if (we && wa == 32'h400) m_leds = wd[15:0];
    if (we && wa == 32'h414) m_seg  = wd[15:0];
    for (int k = 0; k < 2; k++) begin
      p       = (k == 0) ? 1 : 4;
      tick    = m_en[k] && (m_phase[k] == p - 1);
      hit     = tick && (m_tcount[k] == m_tcmp[k]);
      n_count = m_tcount[k];
      n_en    = m_en[k];
      n_flag  = m_flag[k];
      if (tick) n_count = hit ? (m_auto[k] ? 32'h0 : m_tcount[k]) : m_tcount[k] + 32'd1;
      if (we && wa == 32'h408) n_count = wd;
      if (we && wa == 32'h410) begin
        n_en = wd[0];
        if (wd[2]) n_flag = 0;
      end
      if (hit) begin
        n_flag = 1;
        if (!m_auto[k]) n_en = 0;
      end
      m_phase[k] = m_en[k] ? (m_phase[k] + 1) % p : 0;
      if (we && wa == 32'h410) m_auto[k] = wd[1];
      if (we && wa == 32'h40C) m_tcmp[k] = wd;
      m_tcount[k] = n_count;
      m_en[k]     = n_en;
      m_flag[k]   = n_flag;
    end
  endtask

  // Drive one access, check all outputs against the model, then advance one clock.
  task automatic cyc(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input int ck = -1, input string tag = "", input logic [31:0] ev = '0);
    logic [31:0] e;
    bit known;
    reset = rst; memwrite = we; addr = a; writedata = wd;
    #1;
    for (int k = 0; k < 2; k++) begin
      e = mexp(k, a, known);
      if (known) check("readdata", rd[k], e);
      check("leds", {16'h0, ld[k]}, {16'h0, m_leds});
      check("seg_value", {16'h0, sg[k]}, {16'h0, m_seg});
      check("timer_irq", {31'h0, irq[k]}, {31'h0, m_flag[k]});
    end
    if (ck >= 0) check(tag, rd[ck], ev);
    @(posedge clk);
    model_step(rst, we, a, wd, switches);
    @(negedge clk);
  endtask

  logic [31:0] ra, rw;
  bit          rwe, rrst;

  initial begin
    reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0; switches = '0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      model_step(1, 0, '0, '0, switches);
    end
    @(negedge clk);

    // Reset values.
    cyc(0, 0, 32'h400, 0, 0, "rst_leds",   32'h0);
    cyc(0, 0, 32'h408, 0, 1, "rst_tcount", 32'h0);
    cyc(0, 0, 32'h40C, 0, 0, "rst_tcmp",   32'hFFFF_FFFF);
    cyc(0, 0, 32'h410, 0, 1, "rst_tctrl",  32'h0);

    // RAM.
    cyc(0, 1, 32'h10, 32'hDEAD_BEEF);
    cyc(0, 1, 32'h14, 32'h1234_5678);
    cyc(0, 0, 32'h10,  0, 0, "ram_10",  32'hDEAD_BEEF);
    cyc(0, 0, 32'h13,  0, 1, "ram_13",  32'hDEAD_BEEF);
    cyc(0, 0, 32'h14,  0, 0, "ram_14",  32'h1234_5678);
    cyc(0, 0, 32'h100, 0, 0, "ram_100", 32'h0);
    // Same-cycle store/load returns the old value.
    cyc(0, 1, 32'h10, 32'h0BAD_F00D, 0, "ram_rmw_old", 32'hDEAD_BEEF);

    // LEDs, 7-seg, unmapped write.
    cyc(0, 1, 32'h400, 32'hABCD_1234);
    cyc(0, 1, 32'h414, 32'h0000_BEEF);
    check("leds_val", {16'h0, ld[0]}, 32'h1234);
    check("seg_val",  {16'h0, sg[1]}, 32'hBEEF);
    cyc(0, 0, 32'h400, 0, 0, "leds_rb", 32'h0000_1234);
    cyc(0, 1, 32'h800, 32'hFFFF);
    cyc(0, 0, 32'h400, 0, 1, "leds_after_800", 32'h0000_1234);
    cyc(0, 0, 32'h414, 0, 0, "seg_after_800",  32'h0000_BEEF);
    cyc(0, 0, 32'h014, 0, 0, "ram_after_800",  32'h1234_5678);

    // Switch synchronizer.
    switches = 16'h00A5;
    cyc(0, 0, 32'h404, 0, 0, "sw_edge0", 32'h0);
    cyc(0, 0, 32'h404, 0, 0, "sw_edge1", 32'h0);
    cyc(0, 0, 32'h404, 0, 0, "sw_edge2", 32'h0000_00A5);

    // One-shot on the PRESCALE=1 instance.
    cyc(0, 1, 32'h40C, 32'd3);
    cyc(0, 1, 32'h410, 32'h1);
    for (int j = 0; j < 5; j++)
      cyc(0, 0, 32'h408, 0, 0, "oneshot_cnt", (j < 3) ? j : 3);
    check("oneshot_irq", {31'h0, irq[0]}, 32'h1);
    cyc(0, 0, 32'h410, 0, 0, "oneshot_tctrl", 32'h4);
    cyc(0, 0, 32'h408, 0, 0, "oneshot_hold",  32'h3);

    // Auto-reload on the PRESCALE=4 instance.
    cyc(1, 0, 32'h0, 0);
    cyc(0, 1, 32'h40C, 32'd1);
    cyc(0, 1, 32'h410, 32'h3);
    for (int j = 0; j < 16; j++)
      cyc(0, 0, 32'h408, 0, 1, "auto_cnt", (j / 4) % 2);
    cyc(0, 0, 32'h410, 0, 1, "auto_flag", 32'h7);
    for (int j = 17; j <= 24; j++) begin
      if (j == 17 || j == 23) cyc(0, 1, 32'h410, 32'h7);
      else if (j == 18)       cyc(0, 0, 32'h410, 0, 1, "auto_clr", 32'h3);
      else if (j == 24)       cyc(0, 0, 32'h410, 0, 1, "auto_setwins", 32'h7);
      else                    cyc(0, 0, 32'h408, 0);
    end

    // Reset mid-run with the timer running and FLAG set.
    cyc(0, 1, 32'h400, 32'h00FF);
    check("pre_rst_irq", {31'h0, irq[1]}, 32'h1);
    cyc(1, 1, 32'h400, 32'hFFFF);
    check("mid_rst_leds", {16'h0, ld[0]}, 32'h0);
    check("mid_rst_irq",  {31'h0, irq[1]}, 32'h0);
    cyc(0, 0, 32'h408, 0, 1, "mid_rst_tcount", 32'h0);
    cyc(0, 0, 32'h40C, 0, 1, "mid_rst_tcmp",   32'hFFFF_FFFF);
    cyc(0, 0, 32'h410, 0, 1, "mid_rst_tctrl",  32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) switches = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2:    ra = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        3, 4, 5, 6: ra = 32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
        7:          ra = 32'($urandom_range(64, 255)) * 4;
        8:          ra = $urandom;
        default:    ra = 32'h400 + (32'($urandom_range(1, 1023)) << 11);
      endcase
      rwe  = ($urandom_range(0, 2) == 0);
      rrst = ($urandom_range(0, 299) == 0);
      rw   = $urandom;
      if ({ra[31:2], 2'b00} == 32'h408 || {ra[31:2], 2'b00} == 32'h40C)
        rw = 32'($urandom_range(0, 5));
      cyc(rrst, rwe, ra, rw);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
